ifetch_queue: RTL and testbench

- Parametrised next-generation instruction fetch stage.
- Decouples instruction memory from decode with a DEPTH-entry prefetch FIFO, so fetch can continue while decode stalls.
- Pre-decodes unconditional B locally and accepts absolute redirects from execute.
- Freezes fetch while the microcode sequencer owns decode.
- Sits between instruction memory (fixed 1-cycle read latency) and decode.

---
 rtl/ifetch_queue_if.sv | 29 ++
 rtl/ifetch_queue.sv | 111 +++++++++++
 tb/tb_ifetch_queue.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_queue_if.sv
// Fetch-stage bus: instruction-memory request/response, execute redirect, microcode hold
// and the decode-side valid/ready stream.
interface ifetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH  = 4
);
  logic                    imem_req;
  logic [ADDR_W-1:0]       imem_addr;
  logic [INST_W-1:0]       imem_data;
  logic                    redirect_valid;
  logic [ADDR_W-1:0]       redirect_pc;
  logic                    ucode_hold;
  logic                    out_valid;
  logic                    out_ready;
  logic [INST_W-1:0]       out_inst;
  logic [ADDR_W-1:0]       out_pc;
  logic [$clog2(DEPTH):0]  fifo_count;

  modport master (
    output imem_req, imem_addr, out_valid, out_inst, out_pc, fifo_count,
    input  imem_data, redirect_valid, redirect_pc, ucode_hold, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_inst, out_pc, fifo_count,
    output imem_data, redirect_valid, redirect_pc, ucode_hold, out_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch stage: DEPTH-entry prefetch FIFO, local B pre-decode, execute redirects.
// Optional: define IFETCH_NOP_SQUASH_EN to drop NOP responses before they enter the FIFO.
module ifetch_queue #(
  parameter int              ADDR_W     = 32,
  parameter int              INST_W     = 32,
  parameter int              DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [6:0]      B_OPCODE   = 7'b1100000,
  parameter logic [6:0]      NOP_OPCODE = 7'b1100100
) (
  input  logic            clk,
  input  logic            rst,
  ifetch_queue_if.master  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(DEPTH);

`ifdef IFETCH_NOP_SQUASH_EN
  localparam bit SQUASH_EN = 1'b1;
`else
  localparam bit SQUASH_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] fetch_pc, resp_pc, b_target;
  logic              pending;
  logic [INST_W-1:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc_mem   [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    credit_used;
  logic              redirect, b_detect, is_nop, enq, deq, req, out_valid;

  // Redirects are ignored in the single post-reset IDLE cycle.
  assign redirect    = bus.redirect_valid && (state != IDLE);
  assign b_detect    = pending && (bus.imem_data[31:25] == B_OPCODE) && !redirect;
  assign is_nop      = bus.imem_data[31:25] == NOP_OPCODE;
  assign enq         = pending && !redirect && !(SQUASH_EN && is_nop);
  assign out_valid   = (count != '0) && (state != HOLD);
  assign deq         = out_valid && bus.out_ready;
  assign credit_used = {1'b0, count} + {{CNT_W{1'b0}}, pending};
  assign b_target    = resp_pc + {{(ADDR_W-16){bus.imem_data[15]}}, bus.imem_data[15:0]};

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_next = state;
    req        = 1'b0;
    unique case (state)
      IDLE: state_next = RUN;
      RUN: begin
        if (bus.ucode_hold) state_next = HOLD;
        req = !redirect && !b_detect && !bus.ucode_hold && (credit_used < DEPTH_C);
      end
      HOLD: if (!bus.ucode_hold) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so each one samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      pending  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      pending <= req;
      if (req) resp_pc <= fetch_pc;

      if (redirect)      fetch_pc <= bus.redirect_pc;
      else if (b_detect) fetch_pc <= b_target;
      else if (req)      fetch_pc <= fetch_pc + ADDR_W'(4);

      // A redirect flushes; a same-cycle dequeue has already been taken by decode.
      if (redirect) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PTR_W'(1);
        if (deq) rd_ptr <= rd_ptr + PTR_W'(1);
        count <= count + CNT_W'(enq) - CNT_W'(deq);
      end
    end
  end

  // NOTE: entry storage has no reset; count and pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[wr_ptr] <= bus.imem_data;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = fetch_pc;
  assign bus.out_valid  = out_valid;
  assign bus.out_inst   = inst_mem[rd_ptr];
  assign bus.out_pc     = pc_mem[rd_ptr];
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_ifetch_queue;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int DEPTH  = 4;
  localparam logic [6:0] B_OP   = 7'b1100000;
  localparam logic [6:0] NOP_OP = 7'b1100100;
`ifdef IFETCH_NOP_SQUASH_EN
  localparam bit SQUASH = 1'b1;
`else
  localparam bit SQUASH = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } entry_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) bus ();

  ifetch_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: FIFO as a queue, one outstanding response, mode 0=IDLE 1=RUN 2=HOLD.
  entry_t      mq[$];
  int          m_mode;
  bit          m_pend;
  logic [31:0] m_pc, m_resp_pc;

  logic [31:0] mem [64];
  bit          last_req;
  logic [31:0] last_addr;
  int          cyc;

  logic [31:0] req_log[$], req_cyc[$], pc_log[$], cnt_log[$];
  bit          val_log[$];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic fill_mem(input int b_pct, input int nop_pct);
    int r;
    logic [15:0] imm;
    for (int i = 0; i < 64; i++) begin
      r   = int'($urandom_range(99));
      imm = 16'(int'($urandom_range(16)) * 4 - 32);
      if (r < b_pct)                mem[i] = {B_OP, 9'($urandom), imm};
      else if (r < b_pct + nop_pct) mem[i] = {NOP_OP, 25'($urandom)};
      else                          mem[i] = {7'($urandom_range(95)), 25'($urandom)};
    end
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.out_ready      = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0040;
    bus.ucode_hold     = 1'b1;
    bus.imem_data      = {B_OP, 25'h1FF};
    @(posedge clk);
    @(negedge clk);
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    rst = 1'b0;
    mq.delete();
    m_mode = 0; m_pend = 1'b0; m_pc = '0; m_resp_pc = '0;
    last_req = 1'b0; last_addr = '0; cyc = 0;
    req_log.delete(); req_cyc.delete(); pc_log.delete(); cnt_log.delete(); val_log.delete();
  endtask

  // One clock cycle: drive inputs mid-cycle, compare against the model, advance the model.
  task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc, input bit hold);
    logic [31:0] d;
    bit m_rv, m_isb, m_req, m_val;
    int occ;
    entry_t e;
    d = last_req ? mem[last_addr[7:2]] : $urandom;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.ucode_hold     = hold;
    bus.imem_data      = d;
    #1;
    occ   = mq.size();
    m_rv  = rv && (m_mode != 0);
    m_isb = m_pend && (d[31:25] == B_OP) && !m_rv;
    m_req = (m_mode == 1) && !m_rv && !m_isb && !hold && (occ + int'(m_pend) < DEPTH);
    m_val = (occ > 0) && (m_mode != 2);

    check("imem_req", 32'(bus.imem_req), 32'(m_req));
    if (m_req) check("imem_addr", bus.imem_addr, m_pc);
    check("out_valid", 32'(bus.out_valid), 32'(m_val));
    if (m_val) begin
      check("out_inst", bus.out_inst, mq[0].inst);
      check("out_pc", bus.out_pc, mq[0].pc);
    end
    check("fifo_count", 32'(bus.fifo_count), 32'(occ));

    if (bus.imem_req) begin
      req_log.push_back(bus.imem_addr);
      req_cyc.push_back(32'(cyc));
    end
    if (bus.out_valid && rdy) pc_log.push_back(bus.out_pc);
    val_log.push_back(bus.out_valid);
    cnt_log.push_back(32'(bus.fifo_count));
    last_req  = bus.imem_req;
    last_addr = bus.imem_addr;

    if (m_val && rdy) void'(mq.pop_front());
    if (m_pend && !m_rv && !(SQUASH && d[31:25] == NOP_OP)) begin
      e.inst = d;
      e.pc   = m_resp_pc;
      mq.push_back(e);
    end
    if (m_rv) mq.delete();
    if (m_req) m_resp_pc = m_pc;
    if (m_rv)       m_pc = rpc;
    else if (m_isb) m_pc = m_resp_pc + {{16{d[15]}}, d[15:0]};
    else if (m_req) m_pc = m_pc + 32'd4;
    m_pend = m_req;
    if (m_mode == 0) m_mode = 1;
    else             m_mode = hold ? 2 : 1;

    cyc++;
    @(negedge clk);
  endtask

  initial begin
    int first;
    int vsum;
    int hold_left;
    bit rdy, rv;
    logic [31:0] rpc;

    // Sequential fetch, decode always ready.
    fill_mem(0, 0);
    do_reset();
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0, 1'b0);
    first = -1;
    for (int i = 0; i < val_log.size(); i++) if (val_log[i] && first < 0) first = i;
    check("first_req_cycle", at(req_cyc, 0), 32'd1);
    check("first_valid_cycle", 32'(first), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("seq_addr", at(req_log, i), 32'(4 * i));
      check("seq_out_pc", at(pc_log, i), 32'(4 * i));
    end

    // Decode stalled: credits stop fetch at DEPTH, then resume without loss.
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b0);
    check("stall_req_total", 32'(req_log.size()), 32'd4);
    check("stall_last_addr", at(req_log, 3), 32'd12);
    check("stall_count", at(cnt_log, 9), 32'd4);
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, '0, 1'b0);
    check("resume_addr", at(req_log, 4), 32'd16);
    for (int i = 0; i < 6; i++) check("resume_out_pc", at(pc_log, i), 32'(4 * i));

    // B at pc 8 with offset -8 loops back to 0.
    mem[2] = {B_OP, 9'h0, 16'hFFF8};
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b0);
    check("b_next_addr", at(req_log, 3), 32'd0);
    check("b_out_pc2", at(pc_log, 2), 32'd8);
    check("b_out_pc3", at(pc_log, 3), 32'd0);

    // Redirect with 3 entries queued and one response in flight.
    fill_mem(0, 0);
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b1, 32'h0000_0100, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b0);
    check("redir_pre_count", at(cnt_log, 5), 32'd3);
    check("redir_post_count", at(cnt_log, 6), 32'd0);
    check("redir_addr", at(req_log, 4), 32'h0000_0100);
    check("redir_addr_cycle", at(req_cyc, 4), 32'd6);

    // Microcode hold for 5 cycles.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, '0, 1'b0);
    vsum = 0;
    for (int i = 5; i < 10; i++) vsum += int'(val_log[i]);
    check("hold_valid_cycles", 32'(vsum), 32'd0);
    check("hold_resume_addr", at(req_log, 3), 32'd12);
    check("hold_resume_cycle", at(req_cyc, 3), 32'd10);
    for (int i = 0; i < 4; i++) check("hold_out_pc", at(pc_log, i), 32'(4 * i));

    // NOP at pc 4.
    mem[1] = {NOP_OP, 25'h0};
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b0);
    check("nop_out_pc0", at(pc_log, 0), 32'd0);
    check("nop_out_pc1", at(pc_log, 1), SQUASH ? 32'd8 : 32'd4);
    check("nop_out_pc2", at(pc_log, 2), SQUASH ? 32'd12 : 32'd8);

    // Randomized traffic: branches, NOPs, redirects, holds, decode back-pressure.
    for (int run = 0; run < 4; run++) begin
      fill_mem(8, 8);
      do_reset();
      hold_left = 0;
      for (int i = 0; i < 500; i++) begin
        rdy = $urandom_range(99) < 70;
        rv  = $urandom_range(19) == 0;
        rpc = {24'h0, 6'($urandom), 2'b00};
        if (hold_left == 0 && $urandom_range(29) == 0) hold_left = int'($urandom_range(6, 1));
        step(rdy, rv, rpc, hold_left > 0);
        if (hold_left > 0) hold_left--;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
